// File: rtl/uart_controller.sv
// uart_controller
//   Memory-mapped UART controller between the peripheral bus and one
//   async_transmitter / async_receiver pair. Outgoing bytes are buffered in a
//   TX FIFO and handed to the transmitter one at a time; received bytes are
//   drained into an RX FIFO through the RxD_data_ready / RxD_clear handshake.
//
//   Register map (addr):
//     0 write : push wdata into TX FIFO (dropped when full)
//     0 read  : pop RX FIFO head (0x00, no pop, when empty)
//     5 read  : status {0, tx_empty&idle, tx_not_full, 0000, rx_not_empty}
//     others  : reads 0x00, writes ignored
//
//   Ports:
//     clk, rst              clock, async active-high reset
//     req, we, addr, wdata  bus request (one-cycle pulse) and its fields
//     rdata, ack            registered response, one cycle after req
//     tx_start, tx_data     to transmitter TxD_start / TxD_data
//     tx_busy               from transmitter TxD_busy
//     rx_ready, rx_data     from receiver RxD_data_ready / RxD_data
//     rx_clear              to receiver RxD_clear
module uart_controller #(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ack,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       rx_ready,
  output logic       rx_clear,
  input  logic [7:0] rx_data
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {T_IDLE, T_START, T_WBUSY, T_WIDLE} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_CLR, R_WAIT} rx_state_t;

  tx_state_t r_tx_state, w_tx_state_nxt;
  rx_state_t r_rx_state, w_rx_state_nxt;

  logic [7:0]     r_tx_mem [TX_DEPTH];
  logic [7:0]     r_rx_mem [RX_DEPTH];
  logic [TX_AW:0] r_tx_wr, r_tx_rd;
  logic [RX_AW:0] r_rx_wr, r_rx_rd;
  logic [7:0]     r_tx_hold;

  logic       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic       w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic       w_wr_data, w_rd_data;
  logic [7:0] w_tx_head, w_rx_head, w_status, w_rdata_nxt;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_full  = (r_tx_wr[TX_AW] != r_tx_rd[TX_AW]) &&
                      (r_tx_wr[TX_AW-1:0] == r_tx_rd[TX_AW-1:0]);
  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[RX_AW] != r_rx_rd[RX_AW]) &&
                      (r_rx_wr[RX_AW-1:0] == r_rx_rd[RX_AW-1:0]);

  assign w_tx_head = r_tx_mem[r_tx_rd[TX_AW-1:0]];
  assign w_rx_head = r_rx_mem[r_rx_rd[RX_AW-1:0]];

  assign w_wr_data = req && we && (addr == 3'd0);
  assign w_rd_data = req && !we && (addr == 3'd0);

  // A pop in the same cycle frees the slot the push then takes, so a full
  // FIFO still accepts when it is being drained that cycle.
  assign w_tx_pop  = (r_tx_state == T_START);
  assign w_tx_push = w_wr_data && (!w_tx_full || w_tx_pop);
  assign w_rx_pop  = w_rd_data && !w_rx_empty;
  assign w_rx_push = (r_rx_state == R_IDLE) && rx_ready && (!w_rx_full || w_rx_pop);

  assign w_status = {1'b0, w_tx_empty && (r_tx_state == T_IDLE), !w_tx_full,
                     4'b0000, !w_rx_empty};

  always_comb begin
    w_rdata_nxt = '0;
    if (req && !we) begin
      case (addr)
        3'd0:    w_rdata_nxt = w_rx_empty ? 8'h00 : w_rx_head;
        3'd5:    w_rdata_nxt = w_status;
        default: w_rdata_nxt = '0;
      endcase
    end
  end

  // Bus response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= req;
      rdata <= w_rdata_nxt;
    end
  end

  // FIFO storage (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[TX_AW-1:0]] <= wdata;
    if (w_rx_push) r_rx_mem[r_rx_wr[RX_AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + (TX_AW+1)'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + (TX_AW+1)'(1);
      if (w_rx_push) r_rx_wr <= r_rx_wr + (RX_AW+1)'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + (RX_AW+1)'(1);
    end
  end

  // TX FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= T_IDLE;
      r_tx_hold  <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      if (r_tx_state == T_START) r_tx_hold <= w_tx_head;
    end
  end

  // From idle, a push landing this cycle already counts as non-empty so the
  // byte is launched in the cycle right after the write.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    tx_start       = 1'b0;
    case (r_tx_state)
      T_IDLE:  if (!w_tx_empty || w_tx_push) w_tx_state_nxt = T_START;
      T_START: begin
        tx_start       = 1'b1;
        w_tx_state_nxt = T_WBUSY;
      end
      T_WBUSY: if (tx_busy)  w_tx_state_nxt = T_WIDLE;
      T_WIDLE: if (!tx_busy) w_tx_state_nxt = T_IDLE;
      default: w_tx_state_nxt = T_IDLE;
    endcase
  end

  // Head is presented live during T_START and held afterwards.
  assign tx_data = (r_tx_state == T_START) ? w_tx_head : r_tx_hold;

  // RX FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rx_state <= R_IDLE;
    else     r_rx_state <= w_rx_state_nxt;
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    rx_clear       = 1'b0;
    case (r_rx_state)
      R_IDLE:  if (w_rx_push) w_rx_state_nxt = R_CLR;
      R_CLR: begin
        rx_clear       = 1'b1;
        w_rx_state_nxt = R_WAIT;
      end
      R_WAIT:  if (!rx_ready) w_rx_state_nxt = R_IDLE;
      default: w_rx_state_nxt = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_controller.sv
module tb_uart_controller;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       ack;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic       rx_ready = 1'b0;
  logic       rx_clear;
  logic [7:0] rx_data = '0;

  uart_controller #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .rx_ready(rx_ready), .rx_clear(rx_clear),
    .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboards
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int   tx_occ = 0;
  int   tx_starts = 0;
  int   clr_cnt = 0;
  int   busy_cnt = 0;
  logic hold = 1'b0;
  logic prev_start = 1'b0;
  logic rx_pend = 1'b0;
  logic txs_at_ack = 1'b0;

  // Transmitter / receiver models plus output-side scoreboard checks
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      chk("tx_pulse_width", prev_start, 1'b0);
      chk("tx_start_expected", tx_q.size() != 0, 1'b1);
      if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q.pop_front());
      if (tx_occ > 0) tx_occ--;
      tx_starts++;
      busy_cnt = 5;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    prev_start = tx_start;
    tx_busy = hold || (busy_cnt > 0);
    if (rx_clear) begin
      chk("rx_clear_pending", rx_pend, 1'b1);
      rx_q.push_back(rx_data);
      rx_pend  = 1'b0;
      rx_ready = 1'b0;
      clr_cnt++;
    end
  end

  task automatic bus(input logic w, input logic [2:0] a, input logic [7:0] d,
                     output logic [7:0] rd);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    if (w && a == 3'd0 && tx_occ < DEPTH) begin
      tx_q.push_back(d);
      tx_occ++;
    end
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    chk("ack", ack, 1'b1);
    rd = rdata;
    txs_at_ack = tx_start;
  endtask

  task automatic wr(input logic [7:0] d);
    logic [7:0] r;
    bus(1'b1, 3'd0, d, r);
  endtask

  task automatic rd_status(input string tag, input logic [7:0] exp);
    logic [7:0] r;
    bus(1'b0, 3'd5, 8'h00, r);
    chk(tag, r, exp);
  endtask

  task automatic rd_data(input string tag, output logic [7:0] r);
    logic [7:0] exp;
    exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
    bus(1'b0, 3'd0, 8'h00, r);
    chk(tag, r, exp);
  endtask

  task automatic rx_present(input logic [7:0] b);
    repeat (2) @(negedge clk);
    rx_data = b; rx_ready = 1'b1; rx_pend = 1'b1;
  endtask

  task automatic wait_rx_clear();
    int k = 0;
    while (rx_pend && k < 50) begin @(negedge clk); k++; end
    chk("rx_clear_timeout", rx_pend, 1'b0);
  endtask

  task automatic wait_tx_idle();
    int k = 0;
    while ((tx_q.size() != 0 || tx_busy) && k < 1000) begin @(negedge clk); k++; end
    chk("tx_idle_timeout", k < 1000, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int s;
    logic [7:0] r;

    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_rx_clear", rx_clear, 1'b0);
    rst = 1'b0;

    rd_status("status_after_reset", 8'h60);

    // Single byte
    s = tx_starts;
    wr(8'h41);
    chk("tx_start_with_ack", txs_at_ack, 1'b1);
    rd_status("status_tx_busy", 8'h20);
    wait_tx_idle();
    rd_status("status_tx_done", 8'h60);
    chk("tx_count_single", tx_starts - s, 1);

    // Fill TX FIFO behind a held transmitter
    s = tx_starts;
    hold = 1'b1;
    for (int i = 0; i <= 16; i++) wr(8'(i));
    rd_status("status_tx_full", 8'h00);
    wr(8'h11);
    rd_status("status_tx_full_after_drop", 8'h00);
    hold = 1'b0;
    wait_tx_idle();
    chk("tx_count_burst", tx_starts - s, 17);
    chk("tx_q_drained", tx_q.size(), 0);
    rd_status("status_after_burst", 8'h60);

    // Two received bytes
    s = clr_cnt;
    rx_present(8'h55); wait_rx_clear();
    rx_present(8'hAA); wait_rx_clear();
    chk("rx_clear_count", clr_cnt - s, 2);
    rd_status("status_rx_avail", 8'h61);
    rd_data("rx_read_0", r);
    rd_data("rx_read_1", r);
    rd_data("rx_read_empty", r);
    chk("rx_empty_value", r, 8'h00);
    rd_status("status_rx_empty", 8'h60);

    // RX FIFO full, 17th byte held off
    s = clr_cnt;
    for (int i = 0; i < 16; i++) begin
      rx_present(8'(8'h10 + i));
      wait_rx_clear();
    end
    rx_present(8'h99);
    repeat (10) @(negedge clk);
    chk("rx_full_held", rx_pend, 1'b1);
    chk("rx_full_no_clear", clr_cnt - s, 16);
    rd_data("rx_full_first", r);
    wait_rx_clear();
    for (int i = 0; i < 16; i++) rd_data("rx_full_drain", r);
    chk("rx_full_last", r, 8'h99);
    rd_status("status_rx_drained", 8'h60);

    // Reset while the transmitter is busy and bytes are queued
    hold = 1'b1;
    for (int i = 0; i < 4; i++) wr(8'(8'hA1 + i));
    repeat (3) @(negedge clk);
    chk("tx_data_before_rst", tx_data, 8'hA1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_start", tx_start, 1'b0);
    chk("mid_rst_tx_data", tx_data, 8'h00);
    chk("mid_rst_rx_clear", rx_clear, 1'b0);
    chk("mid_rst_ack", ack, 1'b0);
    chk("mid_rst_rdata", rdata, 8'h00);
    tx_q.delete();
    tx_occ = 0;
    s = tx_starts;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    hold = 1'b0;
    repeat (30) @(negedge clk);
    chk("no_tx_after_rst", tx_starts - s, 0);
    rd_status("status_after_mid_rst", 8'h60);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
